// File: rtl/i2c_master_byte_ctrl.sv
// Single-byte I2C master: START, 7-bit address + R/W, one data byte (write or read), STOP.
// SCL is built from quarter-periods of CLK_DIV clocks; SDA is open-drain through sda_oe.
module i2c_master_byte_ctrl #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] wdata,
  input  logic       sda_in,
  output logic       scl,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CntLast = CW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    StIdle,
    StStart,
    StAddr,
    StAddrAck,
    StWrData,
    StWrAck,
    StRdData,
    StRdNack,
    StStop
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      quarter_q, quarter_d;
  logic [2:0]      bit_q, bit_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      addr_rw_q;
  logic [7:0]      wdata_q;
  logic            sda_smp_q;

  logic            accept;
  logic            quarter_end;
  logic            sample_now;
  logic            scl_d;
  logic            sda_oe_d;

  // done gates acceptance so a start coinciding with the done pulse is dropped.
  assign accept      = (state_q == StIdle) && start && !done;
  assign quarter_end = (cnt_q == CntLast);
  assign sample_now  = (state_q != StIdle) && quarter_end && (quarter_q == 2'd2);

  always_comb begin
    state_d   = state_q;
    quarter_d = quarter_q;
    bit_d     = bit_q;
    cnt_d     = cnt_q;
    if (state_q == StIdle) begin
      if (accept) begin
        state_d   = StStart;
        quarter_d = '0;
        bit_d     = '0;
        cnt_d     = '0;
      end
    end else if (!quarter_end) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d     = '0;
      quarter_d = quarter_q + 2'd1;
      if (quarter_q == 2'd3) begin
        bit_d = '0;
        unique case (state_q)
          StStart: state_d = StAddr;
          StAddr: begin
            if (bit_q == 3'd7) state_d = StAddrAck;
            else               bit_d   = bit_q + 3'd1;
          end
          StAddrAck: begin
            if (sda_smp_q)         state_d = StStop;
            else if (addr_rw_q[0]) state_d = StRdData;
            else                   state_d = StWrData;
          end
          StWrData: begin
            if (bit_q == 3'd7) state_d = StWrAck;
            else               bit_d   = bit_q + 3'd1;
          end
          StWrAck: state_d = StStop;
          StRdData: begin
            if (bit_q == 3'd7) state_d = StRdNack;
            else               bit_d   = bit_q + 3'd1;
          end
          StRdNack: state_d = StStop;
          StStop:   state_d = StIdle;
          default:  state_d = StIdle;
        endcase
      end
    end
  end

  // Bus levels for the coming cycle, so scl/sda_oe can be registered without lag.
  always_comb begin
    scl_d    = 1'b1;
    sda_oe_d = 1'b0;
    unique case (state_d)
      StIdle: begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
      end
      StStart: begin
        scl_d    = 1'b1;
        sda_oe_d = quarter_d[1];
      end
      StAddr: begin
        scl_d    = quarter_d[1];
        sda_oe_d = ~addr_rw_q[3'd7 - bit_d];
      end
      StWrData: begin
        scl_d    = quarter_d[1];
        sda_oe_d = ~wdata_q[3'd7 - bit_d];
      end
      StStop: begin
        scl_d    = quarter_d[1];
        sda_oe_d = (quarter_d != 2'd3);
      end
      default: begin
        scl_d    = quarter_d[1];
        sda_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      quarter_q <= '0;
      bit_q     <= '0;
      cnt_q     <= '0;
      addr_rw_q <= '0;
      wdata_q   <= '0;
      sda_smp_q <= 1'b1;
      scl       <= 1'b1;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ack_err   <= 1'b0;
      rdata     <= '0;
    end else begin
      state_q   <= state_d;
      quarter_q <= quarter_d;
      bit_q     <= bit_d;
      cnt_q     <= cnt_d;
      scl       <= scl_d;
      sda_oe    <= sda_oe_d;
      busy      <= (state_d != StIdle);
      done      <= (state_q == StStop) && (state_d == StIdle);
      if (accept) begin
        addr_rw_q <= {addr, rw};
        wdata_q   <= wdata;
        ack_err   <= 1'b0;
      end
      if (sample_now) begin
        sda_smp_q <= sda_in;
        if ((state_q == StAddrAck || state_q == StWrAck) && sda_in) begin
          ack_err <= 1'b1;
        end
        if (state_q == StRdData) begin
          rdata <= {rdata[6:0], sda_in};
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_byte_ctrl.sv
// Bench for i2c_master_byte_ctrl: directed table and random transactions checked against a
// quarter-period bus waveform model, plus reset-abort and start-while-busy sequences.
module tb_i2c_master_byte_ctrl;

  localparam int unsigned CLK_DIV = 4;
  // Cycle index (after accept) that falls inside ADDR bit 3.
  localparam int RstK = 16 * int'(CLK_DIV) + int'(CLK_DIV) + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [6:0] addr = '0;
  logic       rw = 1'b0;
  logic [7:0] wdata = '0;
  logic       sda_in = 1'b1;
  logic       scl, sda_oe, busy, done, ack_err;
  logic [7:0] rdata;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
    logic       addr_ack;
    logic       data_ack;
    logic [7:0] rd_byte;
    logic       exp_ack_err;
    int         exp_lat;
    logic [7:0] exp_rdata;
    int         poke_k;
    logic       poke_done;
  } txn_t;

  logic [2:0] wave[$];  // per cycle: {scl, sda_oe, slave pulls SDA low}
  logic [7:0] model_rdata = 8'h00;

  i2c_master_byte_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .addr    (addr),
    .rw      (rw),
    .wdata   (wdata),
    .sda_in  (sda_in),
    .scl     (scl),
    .sda_oe  (sda_oe),
    .busy    (busy),
    .done    (done),
    .ack_err (ack_err),
    .rdata   (rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #50000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add_q(input logic s, input logic oe, input logic sl);
    for (int i = 0; i < int'(CLK_DIV); i++) wave.push_back({s, oe, sl});
  endtask

  task automatic add_bit(input logic oe, input logic sl);
    add_q(1'b0, oe, sl);
    add_q(1'b0, oe, sl);
    add_q(1'b1, oe, sl);
    add_q(1'b1, oe, sl);
  endtask

  task automatic build_wave(input txn_t t);
    logic [7:0] ab;
    ab = {t.addr, t.rw};
    wave.delete();
    add_q(1'b1, 1'b0, 1'b0);
    add_q(1'b1, 1'b0, 1'b0);
    add_q(1'b1, 1'b1, 1'b0);
    add_q(1'b1, 1'b1, 1'b0);
    for (int i = 7; i >= 0; i--) add_bit(~ab[i], 1'b0);
    add_bit(1'b0, t.addr_ack);
    if (t.addr_ack) begin
      if (!t.rw) begin
        for (int i = 7; i >= 0; i--) add_bit(~t.wdata[i], 1'b0);
        add_bit(1'b0, t.data_ack);
      end else begin
        for (int i = 7; i >= 0; i--) add_bit(1'b0, ~t.rd_byte[i]);
        add_bit(1'b0, 1'b0);
      end
    end
    add_q(1'b0, 1'b1, 1'b0);
    add_q(1'b0, 1'b1, 1'b0);
    add_q(1'b1, 1'b1, 1'b0);
    add_q(1'b1, 1'b0, 1'b0);
  endtask

  function automatic txn_t model_expect(input txn_t t);
    txn_t r;
    r = t;
    r.exp_ack_err = !t.addr_ack || (!t.rw && !t.data_ack);
    r.exp_lat     = (t.addr_ack ? 80 : 44) * int'(CLK_DIV) + 1;
    r.exp_rdata   = (t.addr_ack && t.rw) ? t.rd_byte : model_rdata;
    return r;
  endfunction

  task automatic run_txn(input txn_t t);
    int         nw;
    int         wave_err = 0;
    int         first_k = -1;
    int         done_at = -1;
    int         ndone = 0;
    logic       ae_cap = 1'bx;
    logic [7:0] rd_cap = 8'hxx;
    logic [2:0] e;
    build_wave(t);
    nw = wave.size();
    @(negedge clk);
    start = 1'b1;
    addr  = t.addr;
    rw    = t.rw;
    wdata = t.wdata;
    @(negedge clk);
    addr  = 7'($urandom);
    rw    = 1'($urandom);
    wdata = 8'($urandom);
    for (int k = 1; k <= nw + 3; k++) begin
      e = (k <= nw) ? wave[k-1] : 3'b100;
      if (scl !== e[2] || sda_oe !== e[1] || busy !== (k <= nw)) begin
        wave_err++;
        if (first_k < 0) first_k = k;
      end
      if (done === 1'b1) begin
        ndone++;
        if (done_at < 0) begin
          done_at = k;
          ae_cap  = ack_err;
          rd_cap  = rdata;
        end
      end else if (done !== 1'b0) begin
        ndone += 100;
      end
      sda_in = !(sda_oe || e[0]);
      start  = (k == t.poke_k) || (t.poke_done && k == nw + 1);
      if (k == t.poke_k) begin
        addr  = t.addr ^ 7'h55;
        wdata = ~t.wdata;
        rw    = ~t.rw;
      end
      @(negedge clk);
    end
    start  = 1'b0;
    sda_in = 1'b1;
    if (first_k >= 0) $display("  first bus difference at cycle %0d after accept", first_k);
    chk("bus_wave", 32'(wave_err), 32'd0);
    chk("done_cycle", done_at, t.exp_lat);
    chk("done_count", 32'(ndone), 32'd1);
    chk("ack_err", 32'(ae_cap), 32'(t.exp_ack_err));
    chk("rdata", 32'(rd_cap), 32'(t.exp_rdata));
    model_rdata = t.exp_rdata;
  endtask

  task automatic reset_mid_addr();
    int seen_done = 0;
    @(negedge clk);
    start = 1'b1;
    addr  = 7'h2A;
    rw    = 1'b0;
    wdata = 8'h81;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k < RstK; k++) @(negedge clk);
    chk("busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    chk("rst_scl", 32'(scl), 32'd1);
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    for (int k = 0; k < 400; k++) begin
      if (done !== 1'b0 || busy !== 1'b0) seen_done++;
      @(negedge clk);
    end
    chk("quiet_after_rst", 32'(seen_done), 32'd0);
    model_rdata = 8'h00;
  endtask

  txn_t dir[6];
  txn_t t;

  initial begin
    // addr, rw, wdata, addr_ack, data_ack, rd_byte, exp_ack_err, exp_lat, exp_rdata, poke
    dir[0] = '{7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0, 321, 8'h00, 0,   1'b0};
    dir[1] = '{7'h21, 1'b0, 8'h3C, 1'b0, 1'b1, 8'h00, 1'b1, 177, 8'h00, 0,   1'b0};
    dir[2] = '{7'h50, 1'b1, 8'h00, 1'b1, 1'b1, 8'h3C, 1'b0, 321, 8'h3C, 0,   1'b0};
    dir[3] = '{7'h1F, 1'b0, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 321, 8'h3C, 100, 1'b1};
    dir[4] = '{7'h7F, 1'b1, 8'h00, 1'b1, 1'b1, 8'hC3, 1'b0, 321, 8'hC3, 200, 1'b0};
    dir[5] = '{7'h00, 1'b1, 8'h00, 1'b0, 1'b1, 8'h99, 1'b1, 177, 8'hC3, 0,   1'b1};

    rst   = 1'b1;
    start = 1'b1;
    addr  = 7'h7F;
    rw    = 1'b1;
    wdata = 8'hFF;
    repeat (3) @(negedge clk);
    chk("reset_scl", 32'(scl), 32'd1);
    chk("reset_sda_oe", 32'(sda_oe), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_ack_err", 32'(ack_err), 32'd0);
    chk("reset_rdata", 32'(rdata), 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("start_during_rst_ignored", 32'(busy), 32'd0);

    for (int i = 0; i < 6; i++) run_txn(dir[i]);

    for (int i = 0; i < 16; i++) begin
      t.addr      = 7'($urandom);
      t.rw        = 1'($urandom);
      t.wdata     = 8'($urandom);
      t.addr_ack  = ($urandom_range(0, 3) != 0);
      t.data_ack  = ($urandom_range(0, 3) != 0);
      t.rd_byte   = 8'($urandom);
      t.poke_k    = ($urandom_range(0, 1) != 0) ? int'($urandom_range(2, 170)) : 0;
      t.poke_done = 1'($urandom);
      run_txn(model_expect(t));
    end

    reset_mid_addr();
    t = dir[0];
    run_txn(model_expect(t));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2c_master_byte_ctrl.md
I2C_MASTER_BYTE_CTRL -- requirements
Module: i2c_master_byte_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per SCL quarter-period; legal minimum 1.
REQ-002 SHALL have port clk, input, 1: single system clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1: command request, sampled only in IDLE.
REQ-005 SHALL have port addr, input, 7: slave address, captured when start is accepted.
REQ-006 SHALL have port rw, input, 1: transfer direction, 0 = write, 1 = read; captured with addr.
REQ-007 SHALL have port wdata, input, 8: write byte, captured with addr.
REQ-008 SHALL have port sda_in, input, 1: sampled level of the bus SDA pin.
REQ-009 SHALL have port scl, output, 1: SCL level driven by the master.
REQ-010 SHALL have port sda_oe, output, 1: 1 = pull SDA low, 0 = release SDA (open-drain).
REQ-011 SHALL have port busy, output, 1: transaction in progress.
REQ-012 SHALL have port done, output, 1: one-cycle pulse at transaction end.
REQ-013 SHALL have port ack_err, output, 1: last transaction received an address or write-data NACK; valid with done.
REQ-014 SHALL have port rdata, output, 8: byte read; valid from done until the next accepted start.

Function
REQ-015 The block SHALL implement states IDLE, START, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_NACK and STOP.
REQ-016 Each non-IDLE state SHALL divide each bit into quarters Q0–Q3, each lasting exactly CLK_DIV clk cycles, using a quarter counter and a 3-bit bit counter.
REQ-017 In data and ACK bits:
- scl = 0 during Q0 and Q1, and scl = 1 during Q2 and Q3.
- sda_oe SHALL change only on the first cycle of Q0.
- sda_in SHALL be sampled on the last cycle of Q2.
REQ-018 In START:
- scl = 1 for all quarters.
- sda_oe = 0 in Q0 and Q1, and sda_oe = 1 in Q2 and Q3.
REQ-019 In STOP:
- sda_oe = 1 in Q0–Q2, and sda_oe = 0 in Q3.
- scl = 0 in Q0 and Q1, and scl = 1 in Q2 and Q3.
REQ-020 A start accepted in IDLE SHALL:
- capture addr, rw and wdata;
- clear ack_err;
- enter START on the next cycle, with busy = 1 from that cycle.
REQ-021 ADDR SHALL shift out {addr, rw} MSB first, 8 bits, with sda_oe = ~bit.
REQ-022 In ADDR_ACK, sda_oe SHALL be 0. Then:
- sda_in = 0: go to WR_DATA if rw = 0, or RD_DATA if rw = 1.
- sda_in = 1: set ack_err = 1 and go to STOP.
REQ-023 WR_DATA SHALL shift out wdata MSB first.
REQ-024 WR_ACK SHALL release SDA and set ack_err = 1 if sda_in = 1; it SHALL then go to STOP.
REQ-025 RD_DATA SHALL:
- keep sda_oe = 0;
- shift sda_in into rdata MSB first, one bit per Q2 sample.
REQ-026 RD_NACK SHALL hold sda_oe = 0 (master NACK, single-byte read) and then go to STOP.
REQ-027 The cycle after STOP Q3 ends SHALL be IDLE with:
- done = 1 for exactly one cycle;
- busy = 0 in that same cycle.
REQ-028 Total latency from the start-accept cycle to done SHALL be:
- 80*CLK_DIV + 1 cycles for a completed transaction;
- 44*CLK_DIV + 1 cycles on an address NACK.
REQ-029 start asserted while busy = 1 SHALL be ignored, and the captured operands SHALL remain unchanged.
REQ-030 start asserted in the same cycle as done SHALL be ignored; it is accepted only in IDLE with done = 0.
REQ-031 In IDLE, scl SHALL be 1 and sda_oe SHALL be 0.

Reset
REQ-032 On any clk edge with rst = 1, the block SHALL go to IDLE with:
- scl = 1, sda_oe = 0, busy = 0, done = 0;
- ack_err = 0, rdata = 8'h00;
- quarter and bit counters = 0.
REQ-033 Reset during a transaction SHALL abort it immediately, without generating STOP, and SHALL NOT produce a done pulse.
REQ-034 start SHALL be ignored in any cycle where rst = 1.

Verification
REQ-035 (CLK_DIV = 4) Write: addr = 7'h50, rw = 0, wdata = 8'hA5, slave ACKs both bytes.
- SDA bits: 1,0,1,0,0,0,0,0, ACK, then 1,0,1,0,0,1,0,1, ACK.
- STOP is generated.
- done occurs at cycle 321 after accept, with ack_err = 0.
REQ-036 Address NACK: addr = 7'h21, sda_in held 1.
- ack_err = 1.
- No data bits are driven; STOP follows ADDR_ACK.
- done occurs at cycle 177.
REQ-037 Read: addr = 7'h50, rw = 1, slave drives 8'h3C after its ACK.
- rdata = 8'h3C.
- sda_oe = 0 during the 9th bit (NACK).
- ack_err = 0.
REQ-038 start pulsed while busy with different addr and wdata: the first transaction completes unchanged, and exactly one done is produced.
REQ-039 rst asserted during ADDR bit 3: on the next cycle scl = 1, sda_oe = 0 and busy = 0, with no done pulse; a following start completes normally.
